// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - shared types and constants for the seven-segment display arbiter
package seg_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_t;

    // Nibble positions on the display driver bus; digit 3 is the leftmost
    localparam int DIG3_MSB = 15;
    localparam int DIG3_LSB = 12;
    localparam int DIG2_MSB = 11;
    localparam int DIG2_LSB = 8;
    localparam int DIG1_MSB = 7;
    localparam int DIG1_LSB = 4;
    localparam int DIG0_MSB = 3;
    localparam int DIG0_LSB = 0;

    localparam logic [15:0] DEFAULT_IDLE_PATTERN = 16'h0000;

    // One-hot owner as seen by the requesters; idle shows no owner
    function automatic logic [1:0] grant_of(input arb_state_t s);
        case (s)
            OWN0:    return 2'b01;
            OWN1:    return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// rtl/seg_display_arbiter_if.sv - requester/display bundle shared by the arbiter and its users
interface seg_display_arbiter_if;
    logic [1:0]  req;
    logic [15:0] data0;
    logic [15:0] data1;
    logic [1:0]  grant;
    logic [15:0] disp;
    logic        switched;

    // Requester side: drives requests and digits, observes ownership
    modport master (
        output req, data0, data1,
        input  grant, disp, switched
    );

    // Arbiter side
    modport slave (
        input  req, data0, data1,
        output grant, disp, switched
    );
endinterface

// File: rtl/seg_display_arbiter_hold_timer.sv
// rtl/seg_display_arbiter_hold_timer.sv - saturating minimum-ownership timer
module hold_timer #(
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int CNT_W       = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Count owned cycles from zero at each state entry, parking at the last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign done = (cnt == LAST);

endmodule

// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - round-robin owner selection for the shared four-digit display
module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter int          HOLD_CYCLES  = 100_000_000,
    parameter int          CNT_W        = 27,
    parameter logic [15:0] IDLE_PATTERN = DEFAULT_IDLE_PATTERN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_display_arbiter_if.slave  bus
);

    arb_state_t  state;
    arb_state_t  state_nxt;
    logic        last_q;
    logic [15:0] disp_q;
    logic        switched_q;
    logic        hold_done;
    logic        state_change;

    assign state_change = (state_nxt != state);

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_change),
        .en    (state != IDLE),
        .done  (hold_done)
    );

    // Ownership decisions: hold is absolute, then the other side gets priority
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                case (bus.req)
                    2'b01:   state_nxt = OWN0;
                    2'b10:   state_nxt = OWN1;
                    2'b11:   state_nxt = last_q ? OWN0 : OWN1;
                    default: state_nxt = IDLE;
                endcase
            end
            OWN0: begin
                if (hold_done) begin
                    if (bus.req[1])      state_nxt = OWN1;
                    else if (!bus.req[0]) state_nxt = IDLE;
                end
            end
            OWN1: begin
                if (hold_done) begin
                    if (bus.req[0])      state_nxt = OWN0;
                    else if (!bus.req[1]) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; last starts at 1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            last_q <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state_change && (state_nxt == OWN0)) last_q <= 1'b0;
            if (state_change && (state_nxt == OWN1)) last_q <= 1'b1;
        end
    end

    // Display snapshot: load on entry, track the owner only while it still requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= IDLE_PATTERN;
        end else if (state_change) begin
            case (state_nxt)
                OWN0:    disp_q <= bus.data0;
                OWN1:    disp_q <= bus.data1;
                default: disp_q <= IDLE_PATTERN;
            endcase
        end else if ((state == OWN0) && bus.req[0]) begin
            disp_q <= bus.data0;
        end else if ((state == OWN1) && bus.req[1]) begin
            disp_q <= bus.data1;
        end
    end

    // Grant is a pure decode of state, so any state change is a grant change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            switched_q <= 1'b0;
        end else begin
            switched_q <= state_change;
        end
    end

    assign bus.grant    = grant_of(state);
    assign bus.switched = switched_q;
    assign bus.disp     = {disp_q[DIG3_MSB:DIG3_LSB], disp_q[DIG2_MSB:DIG2_LSB],
                           disp_q[DIG1_MSB:DIG1_LSB], disp_q[DIG0_MSB:DIG0_LSB]};

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb/tb_seg_display_arbiter.sv - directed and randomized checks of the display arbiter
module tb_seg_display_arbiter;

    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seg_display_arbiter_if bus ();

    seg_display_arbiter #(
        .HOLD_CYCLES  (HOLD),
        .CNT_W        (3),
        .IDLE_PATTERN (16'h0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Reference: owner index (-1 idle), edges since the grant, last winner
    int          m_owner;
    int          m_age;
    int          m_last;
    logic [15:0] m_disp;
    logic        m_sw;

    function automatic logic [1:0] m_grant();
        if (m_owner < 0) return 2'b00;
        return (m_owner == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_last  = 1;
        m_disp  = 16'h0000;
        m_sw    = 1'b0;
    endtask

    function automatic logic [15:0] data_of(input int k);
        return (k == 0) ? bus.data0 : bus.data1;
    endfunction

    task automatic take(input int k);
        m_owner = k;
        m_age   = 0;
        m_last  = k;
        m_disp  = data_of(k);
        m_sw    = 1'b1;
    endtask

    task automatic model_edge();
        int other;
        m_sw = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (m_owner < 0) begin
            if (bus.req == 2'b11)   take(1 - m_last);
            else if (bus.req[0])    take(0);
            else if (bus.req[1])    take(1);
        end else if (m_age < HOLD - 1) begin
            m_age++;
            if (bus.req[m_owner]) m_disp = data_of(m_owner);
        end else begin
            other = 1 - m_owner;
            if (bus.req[other]) begin
                take(other);
            end else if (bus.req[m_owner]) begin
                m_disp = data_of(m_owner);
            end else begin
                m_owner = -1;
                m_age   = 0;
                m_disp  = 16'h0000;
                m_sw    = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk({tag, " grant"},    16'(bus.grant),    16'(m_grant()));
        chk({tag, " disp"},     bus.disp,          m_disp);
        chk({tag, " switched"}, 16'(bus.switched), 16'(m_sw));
    endtask

    task automatic cycs(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " grant"},    16'(bus.grant),    16'h0000);
        chk({tag, " disp"},     bus.disp,          16'h0000);
        chk({tag, " switched"}, 16'(bus.switched), 16'h0000);
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.req   = 2'b00;
        bus.data0 = 16'h0000;
        bus.data1 = 16'h0000;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk_idle("reset_init");
        rst_n = 1'b1;

        // Single requester, data tracking, then release
        bus.req = 2'b01; bus.data0 = 16'h1234;
        cyc("s2_grant");
        chk("s2 grant01", 16'(bus.grant), 16'h0001);
        chk("s2 disp1234", bus.disp, 16'h1234);
        chk("s2 switched", 16'(bus.switched), 16'h0001);
        bus.data0 = 16'h5678;
        cyc("s2_follow");
        chk("s2 disp5678", bus.disp, 16'h5678);
        chk("s2 sw_pulse", 16'(bus.switched), 16'h0000);
        bus.req = 2'b00;
        cycs("s2_release", 3);
        chk("s2 idle_grant", 16'(bus.grant), 16'h0000);

        // Reset in the middle of an OWN1 hold
        bus.req = 2'b10; bus.data1 = 16'h9999;
        cycs("s1_own1", 2);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_idle("s1_async");
        bus.req = 2'b00;
        cycs("s1_in_reset", 2);
        rst_n = 1'b1;
        cycs("s1_after", 2);
        chk_idle("s1_hold");

        // Tie after reset: 0 first, then alternate after each hold
        bus.req = 2'b11; bus.data0 = 16'h1111; bus.data1 = 16'h2222;
        cyc("s3_first");
        chk("s3 grant01", 16'(bus.grant), 16'h0001);
        cycs("s3_hold0", 3);
        cyc("s3_swap");
        chk("s3 grant10", 16'(bus.grant), 16'h0002);
        chk("s3 disp2222", bus.disp, 16'h2222);
        chk("s3 switched", 16'(bus.switched), 16'h0001);
        cycs("s3_hold1", 3);
        cyc("s3_back");
        chk("s3 grant01b", 16'(bus.grant), 16'h0001);
        bus.req = 2'b00;
        cycs("s3_drain", 5);

        // Early release keeps the snapshot until the hold ends
        bus.req = 2'b01; bus.data0 = 16'hABCD;
        cyc("s4_grant");
        bus.req = 2'b00; bus.data0 = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            cyc("s4_frozen");
            chk("s4 dispABCD", bus.disp, 16'hABCD);
        end
        cyc("s4_release");
        chk("s4 grant00", 16'(bus.grant), 16'h0000);
        chk("s4 disp0000", bus.disp, 16'h0000);

        // Preemption only once the hold is complete
        bus.req = 2'b01; bus.data0 = 16'h5555; bus.data1 = 16'h6666;
        cycs("s5_own0", 2);
        bus.req = 2'b11;
        cyc("s5_wait_a");
        chk("s5 still01a", 16'(bus.grant), 16'h0001);
        cyc("s5_wait_b");
        chk("s5 still01b", 16'(bus.grant), 16'h0001);
        cyc("s5_preempt");
        chk("s5 grant10", 16'(bus.grant), 16'h0002);
        chk("s5 disp6666", bus.disp, 16'h6666);
        bus.req = 2'b00;
        cycs("s5_drain", 5);

        // Short request inside another owner's hold is never granted
        bus.req = 2'b01;
        cyc("s6_own0");
        bus.req = 2'b11;
        cycs("s6_short", 2);
        bus.req = 2'b01;
        for (int i = 0; i < 4; i++) begin
            cyc("s6_keep");
            chk("s6 grant01", 16'(bus.grant), 16'h0001);
        end
        bus.req = 2'b00;
        cycs("s6_drain", 5);

        // Randomized traffic against the reference
        for (int n = 0; n < 600; n++) begin
            if ((n % 3) == 0) bus.req = 2'($urandom_range(0, 3));
            bus.data0 = 16'($urandom);
            bus.data1 = 16'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                chk_idle("rnd_async_reset");
                cyc("rnd_in_reset");
                rst_n = 1'b1;
            end else begin
                cyc("rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Shares the four-digit seven-segment display between two requesters, for example a game/score path and a status/message path. A one-hot grant is given to one requester at a time. Each ownership is held for a minimum time so the display never flickers between sources. Two-way contention is resolved round-robin. The 16-bit output drives the display driver's four nibble inputs: bits [15:12] go to the leftmost digit, bits [3:0] to the rightmost.

## Interface
Parameters:
- HOLD_CYCLES, 100_000_000 — minimum ownership time in clk cycles (1 s at 100 MHz); must be ≥ 2
- CNT_W, 27 — hold-timer width; must satisfy 2^CNT_W ≥ HOLD_CYCLES
- IDLE_PATTERN, 16'h0000 — value shown while no requester owns the display

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous and active-low
- req  in  2  request per requester; level-sensitive, held high while display is wanted
- data0  in  16  requester 0 digits, nibble 3 = leftmost
- data1  in  16  requester 1 digits
- grant  out  2  one-hot owner, or 2'b00 when idle
- disp  out  16  registered digits to the display driver
- switched  out  1  one-cycle pulse on every cycle in which grant changes

## Operation
- **FSM states:** IDLE, OWN0, OWN1. The encoding comes from the package.
- **Hold timer:**
  - Clears to 0 on every state entry.
  - Increments each cycle while in OWN0/OWN1 and saturates at HOLD_CYCLES-1.
  - hold_done = (timer == HOLD_CYCLES-1).
- **last pointer:** 1 bit, holds the index of the most recent owner. It updates on every entry into OWNk.
- **From IDLE:**
  - Exactly one req high: go to the corresponding OWNk.
  - Both high: go to OWN(~last).
  - Neither: stay in IDLE.
- **From OWNk:**
  - hold_done=0: stay, regardless of req.
  - hold_done=1 and req[~k]=1: go to OWN(~k). This is the fairness preemption, and it applies even if req[k] is still high.
  - hold_done=1, req[~k]=0, req[k]=1: stay. The timer stays saturated.
  - hold_done=1, both req low: go to IDLE.
- **disp in OWNk:** loads data_k on each cycle that req[k]=1. When req[k]=0, disp holds its last value (frozen snapshot), so a requester that releases early keeps its final value on screen until the hold ends.
- **disp on entry:**
  - Entry to OWNk loads data_k on that same edge.
  - Entry to IDLE loads IDLE_PATTERN.
- **grant:** decoded from the state register: IDLE→00, OWN0→01, OWN1→10.
- **switched:** registered. It is 1 for exactly the cycle following any state change in which grant differs from the previous grant.
- **Reset (asserted at any time, including mid-hold):**
  - Immediately: state=IDLE, grant=00, disp=IDLE_PATTERN, switched=0, timer=0, last=1. Requester 0 therefore wins the first tie.
  - Outputs remain at these values until the first clk edge after rst_n deasserts.

## Timing
- Grant latency is 1 cycle: req sampled high at edge t gives grant and disp = data_k valid after edge t.
- disp latency is 1 cycle from data_k while owned.
- A minimum of HOLD_CYCLES cycles passes between an owner's grant edge and its earliest possible release edge.
- Handover to the other requester is direct: grant goes 01→10 in one edge with no idle cycle, and disp loads data1 on that same edge.
- Release to IDLE takes 1 cycle. A new request seen in IDLE is granted on the next edge, so IDLE lasts at least 1 cycle.
- A req pulse shorter than 1 cycle between edges is ignored.
- A req that rises and falls entirely within another owner's hold is never granted.

## Structure
- **Package `seg_disp_pkg`:**
  - `arb_state_t` enum {IDLE, OWN0, OWN1}.
  - Nibble-index constants (DIG3_MSB=15 … DIG0_LSB=0).
  - Default IDLE_PATTERN.
- **Sub-module `hold_timer`:**
  - Parameters HOLD_CYCLES and CNT_W.
  - Inputs: clk, rst_n, clear, en.
  - Output: done.
  - Saturating counter.
- The arbiter top level contains the FSM, the last pointer, the disp register and the switched register.

## Test plan
All scenarios run with HOLD_CYCLES=4.
1. **Reset values:** assert rst_n=0 mid-OWN1 → grant=00, disp=16'h0000 and switched=0 before the next clk edge. After release with req=00, these values hold.
2. **Single requester:** req=01, data0=16'h1234 → after edge 1, grant=01, disp=16'h1234 and switched=1 for 1 cycle. Change data0 to 16'h5678 → disp follows 1 cycle later.
3. **Tie after reset:** req=11 from IDLE → grant=01 (last=1). Hold 4 cycles → grant=10, disp=data1 and switched pulses. After another 4 cycles → grant=01 again.
4. **Early release:** owner 0 drops req after 1 cycle, data0 value 16'hABCD → disp stays 16'hABCD until hold_done. The next edge gives grant=00 and disp=16'h0000.
5. **Preemption while held:** req[0] held continuously, req[1] rises at cycle 2 of OWN0 → switch to OWN1 exactly when hold_done is reached, not earlier.
6. **Short request during hold:** req[1] high for 2 cycles during OWN0's hold only → never granted, and grant stays 01.
